data_pipe_interconnect_ss_m0: RTL and testbench
===============================================

// Module: data_pipe_interconnect_SS_M0
// PURPOSE
//  8-to-1 merge interconnect for data_inf streams: selects one of eight upstream slave ports (s00..s07)
//  and forwards its beats to a single downstream master port (m00) through a 2-entry registered pipe
//  (output connector register + skid buffer). Path is chosen by sw/sw_vld and may only change while the
//  pipe is empty. Used wherever several producers share one consumer (e.g. I2C master command/data merge).
// PARAMETERS
//  DSIZE  8  width of data_inf.data on all ports
// PORTS
//  clock     in   1      system clock
//  rst_n     in   1      synchronous reset, active low
//  clk_en    in   1      global qualifier; when 0 every register holds
//  sw_vld    in   1      requested path is valid (0 = block all inputs)
//  sw        in   3      requested upstream port index 0..7
//  curr_path out  3      currently latched path index
//  s00..s07  data_inf.slaver  DSIZE  upstream inputs (valid,data in; ready out)
//  m00       data_inf.master  DSIZE  downstream output (valid,data out; ready in)
// BEHAVIOUR
//  Reset: state=IDLE, curr_path=0, curr_path_vld=0, all sXX.ready=0, m00.valid=0, m00.data=0, buffer cleared.
//  Defs: sel = s[curr_path]; push = sel.valid & sel.ready & clk_en; pop = m00.valid & m00.ready & clk_en.
//  States (nstate evaluated every cycle; transitions only when clk_en=1, else hold):
//   IDLE  -> EMPTY unconditionally (one cycle after reset release; ready stays 0).
//   EMPTY : push -> ONE; else stay.
//   ONE   : push&!pop -> TWO; !push&pop -> EMPTY; push&pop or neither -> ONE.
//   TWO   : pop -> ONE; else stay (push impossible, ready=0).
//  Path latch: curr_path<=sw, curr_path_vld<=sw_vld on every clk_en cycle where nstate is IDLE or EMPTY;
//   frozen in ONE/TWO. A push in EMPTY freezes the path that accepted it (nstate=ONE).
//  Ready: ready_reg <= curr_path_vld_next & (nstate==EMPTY|ONE); registered, never combinational from m00.ready.
//   sK.ready = ready_reg & (curr_path==K); all non-selected ports ready=0.
//  Connector (drives m00.data, m00.valid = conn_vld):
//   EMPTY/ONE with push and (conn empty or pop) -> conn<=sel.data, conn_vld=1.
//   ONE push&!pop -> buf<=sel.data, buf_vld=1 (conn unchanged).
//   TWO pop -> conn<=buf, buf_vld=0.  ONE !push&pop -> conn_vld=0 (data holds).
//  Latency: beat accepted in cycle N appears on m00 in cycle N+1; full throughput 1 beat/cycle with m00.ready=1.
//  Ordering: strictly in-order; no beat dropped or duplicated; no overflow state (ready deasserts before buf full).
//  m00.valid never drops without a pop; m00.data stable while valid & !ready.
//  clk_en=0 mid-transfer: state, data, valid, ready, curr_path all hold; no push/pop counted.
//  sw change while ONE/TWO: ignored until pipe drains to EMPTY; then new path latched next cycle.
//  sw_vld=0 in EMPTY: all ready=0, m00.valid=0 once drained.
//  Reset mid-operation: pipe contents discarded, outputs to reset values next edge.
// TESTING
//  1 sw=3,sw_vld=1; s03 sends 0x11,0x22,0x33 b2b, m00.ready=1 -> m00 0x11,0x22,0x33 on cycles N+1..N+3, no gaps.
//  2 s03 streams 0xA0..; m00.ready=0 -> after 2 accepts s03.ready=0 (state TWO); ready=1 -> 0xA0,0xA1 in order.
//  3 sw=5 while state ONE -> curr_path stays 3, s05.ready=0; after pop to EMPTY curr_path=5 next cycle.
//  4 s01 and s06 both valid, sw=6 -> only s06.ready toggles; s01 data never appears on m00.
//  5 clk_en low 3 cycles mid-stream with m00.ready=1 -> no beat lost/duplicated, m00 outputs frozen.
//  6 rst_n=0 while TWO holding 0x55,0x66 -> next edge m00.valid=0, all ready=0, curr_path=0, state IDLE.

Source files
------------

// File: rtl/data_pipe_interconnect_ss_m0.sv
// 8-to-1 stream merge: one latched upstream port feeds m00 through a two-entry
// registered pipe (connector register plus skid buffer) with registered ready.
module data_pipe_interconnect_ss_m0 #(
  parameter int DSIZE = 8
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             clk_en,
  input  logic             sw_vld,
  input  logic [2:0]       sw,
  output logic [2:0]       curr_path,
  input  logic             s00_valid,
  input  logic [DSIZE-1:0] s00_data,
  output logic             s00_ready,
  input  logic             s01_valid,
  input  logic [DSIZE-1:0] s01_data,
  output logic             s01_ready,
  input  logic             s02_valid,
  input  logic [DSIZE-1:0] s02_data,
  output logic             s02_ready,
  input  logic             s03_valid,
  input  logic [DSIZE-1:0] s03_data,
  output logic             s03_ready,
  input  logic             s04_valid,
  input  logic [DSIZE-1:0] s04_data,
  output logic             s04_ready,
  input  logic             s05_valid,
  input  logic [DSIZE-1:0] s05_data,
  output logic             s05_ready,
  input  logic             s06_valid,
  input  logic [DSIZE-1:0] s06_data,
  output logic             s06_ready,
  input  logic             s07_valid,
  input  logic [DSIZE-1:0] s07_data,
  output logic             s07_ready,
  output logic             m00_valid,
  output logic [DSIZE-1:0] m00_data,
  input  logic             m00_ready
);

  typedef enum logic [1:0] {IDLE, EMPTY, ONE, TWO} state_t;

  state_t           state;
  state_t           nstate;
  logic [7:0]       s_valid;
  logic [DSIZE-1:0] s_data [8];
  logic [7:0]       s_ready;
  logic             sel_valid;
  logic [DSIZE-1:0] sel_data;
  logic             ready_reg;
  logic             curr_path_vld;
  logic             path_vld_next;
  logic             latch_path;
  logic             push;
  logic             pop;
  logic             conn_vld;
  logic [DSIZE-1:0] conn_data;
  logic [DSIZE-1:0] buf_data;

  assign s_valid   = {s07_valid, s06_valid, s05_valid, s04_valid,
                      s03_valid, s02_valid, s01_valid, s00_valid};
  assign s_data[0] = s00_data;
  assign s_data[1] = s01_data;
  assign s_data[2] = s02_data;
  assign s_data[3] = s03_data;
  assign s_data[4] = s04_data;
  assign s_data[5] = s05_data;
  assign s_data[6] = s06_data;
  assign s_data[7] = s07_data;

  always_comb begin
    s_ready            = '0;
    s_ready[curr_path] = ready_reg;
  end

  assign s00_ready = s_ready[0];
  assign s01_ready = s_ready[1];
  assign s02_ready = s_ready[2];
  assign s03_ready = s_ready[3];
  assign s04_ready = s_ready[4];
  assign s05_ready = s_ready[5];
  assign s06_ready = s_ready[6];
  assign s07_ready = s_ready[7];

  assign sel_valid = s_valid[curr_path];
  assign sel_data  = s_data[curr_path];
  assign push      = sel_valid & ready_reg & clk_en;
  assign pop       = conn_vld & m00_ready & clk_en;

  assign m00_valid = conn_vld;
  assign m00_data  = conn_data;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clk_en) begin
      state <= nstate;
    end
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:  nstate = EMPTY;
      EMPTY: if (push) nstate = ONE;
      ONE: begin
        if (push && !pop)      nstate = TWO;
        else if (!push && pop) nstate = EMPTY;
      end
      TWO:   if (pop) nstate = ONE;
      default: nstate = IDLE;
    endcase
  end

  // The path may only move while the pipe will be empty after this edge, so a
  // push in EMPTY keeps the port that supplied the beat.
  assign latch_path    = (nstate == IDLE) || (nstate == EMPTY);
  assign path_vld_next = latch_path ? sw_vld : curr_path_vld;

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      curr_path     <= '0;
      curr_path_vld <= 1'b0;
      ready_reg     <= 1'b0;
    end else if (clk_en) begin
      if (latch_path) begin
        curr_path     <= sw;
        curr_path_vld <= sw_vld;
      end
      ready_reg <= path_vld_next && ((nstate == EMPTY) || (nstate == ONE));
    end
  end

  always_ff @(posedge clock) begin
    if (!rst_n) begin
      conn_vld  <= 1'b0;
      conn_data <= '0;
      buf_data  <= '0;
    end else if (clk_en) begin
      case (state)
        EMPTY: begin
          if (push) begin
            conn_data <= sel_data;
            conn_vld  <= 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            conn_data <= sel_data;
          end else if (push) begin
            buf_data <= sel_data;
          end else if (pop) begin
            conn_vld <= 1'b0;
          end
        end
        TWO: begin
          if (pop) conn_data <= buf_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_pipe_interconnect_ss_m0.sv
// Randomised and directed checks of the 8-to-1 merge pipe against a queue-based
// occupancy model of the interconnect.
module tb_data_pipe_interconnect_ss_m0;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       clk_en = 1'b1;
  logic       sw_vld = 1'b0;
  logic [2:0] sw = '0;
  logic [7:0] s_valid = '0;
  logic [7:0] s_data [8];
  wire  [7:0] s_ready;
  wire  [2:0] curr_path;
  wire        m00_valid;
  wire  [7:0] m00_data;
  logic       m00_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  // Reference model: the pipe is a FIFO of at most two beats.
  logic [7:0] mq[$];
  logic [2:0] m_path;
  logic       m_pvld;
  logic       m_rdy;
  logic [7:0] m_data;

  wire [19:0] dut_vec = {curr_path, s_ready, m00_valid, m00_data};

  always #5 clock = ~clock;

  data_pipe_interconnect_ss_m0 #(.DSIZE(8)) dut (
    .clock(clock), .rst_n(rst_n), .clk_en(clk_en), .sw_vld(sw_vld), .sw(sw),
    .curr_path(curr_path),
    .s00_valid(s_valid[0]), .s00_data(s_data[0]), .s00_ready(s_ready[0]),
    .s01_valid(s_valid[1]), .s01_data(s_data[1]), .s01_ready(s_ready[1]),
    .s02_valid(s_valid[2]), .s02_data(s_data[2]), .s02_ready(s_ready[2]),
    .s03_valid(s_valid[3]), .s03_data(s_data[3]), .s03_ready(s_ready[3]),
    .s04_valid(s_valid[4]), .s04_data(s_data[4]), .s04_ready(s_ready[4]),
    .s05_valid(s_valid[5]), .s05_data(s_data[5]), .s05_ready(s_ready[5]),
    .s06_valid(s_valid[6]), .s06_data(s_data[6]), .s06_ready(s_ready[6]),
    .s07_valid(s_valid[7]), .s07_data(s_data[7]), .s07_ready(s_ready[7]),
    .m00_valid(m00_valid), .m00_data(m00_data), .m00_ready(m00_ready)
  );

  function automatic logic [19:0] exp_vec();
    logic [7:0] rdy;
    rdy = '0;
    if (m_rdy) rdy[m_path] = 1'b1;
    return {m_path, rdy, (mq.size() > 0), m_data};
  endfunction

  task automatic tick();
    logic push;
    logic pop;
    @(posedge clock);
    if (!rst_n) begin
      mq.delete();
      m_path = '0; m_pvld = 1'b0; m_rdy = 1'b0; m_data = '0;
    end else if (clk_en) begin
      push = s_valid[m_path] && m_rdy;
      pop  = (mq.size() > 0) && m00_ready;
      if (pop) void'(mq.pop_front());
      if (push) mq.push_back(s_data[m_path]);
      if (mq.size() == 0) begin
        m_path = sw;
        m_pvld = sw_vld;
      end
      m_rdy = m_pvld && (mq.size() < 2);
      if (mq.size() > 0) m_data = mq[0];
    end
    #1;
  endtask

  task automatic do_reset();
    s_valid = '0; m00_ready = 1'b0; clk_en = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    sw = 3'd4; sw_vld = 1'b1;
    do_reset();
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++;
      $display("FAIL reset_values got=%h exp=%h", dut_vec, 20'h0);
    end
    tick();
    checks++;
    if (curr_path !== 3'd4 || s_ready !== 8'h10) begin
      errors++;
      $display("FAIL reset_release got path=%0d ready=%h exp path=4 ready=10", curr_path, s_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] beats [3];
    beats[0] = 8'h11; beats[1] = 8'h22; beats[2] = 8'h33;
    sw = 3'd3; sw_vld = 1'b1;
    do_reset();
    tick();
    m00_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_valid[3] = 1'b1; s_data[3] = beats[i];
      tick();
      checks++;
      if (m00_valid !== 1'b1 || m00_data !== beats[i]) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b d=%h exp v=1 d=%h", i, m00_valid, m00_data, beats[i]);
      end
    end
    s_valid[3] = 1'b0;
    tick();
    checks++;
    if (dut_vec !== exp_vec() || m00_valid !== 1'b0) begin
      errors++;
      $display("FAIL b2b_drain got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_backpressure();
    sw = 3'd3; sw_vld = 1'b1;
    do_reset();
    tick();
    for (int i = 0; i < 4; i++) begin
      s_valid[3] = 1'b1; s_data[3] = 8'hA0 + 8'(i < 2 ? i : 2);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL bp_fill%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (s_ready[3] !== 1'b0 || m00_data !== 8'hA0) begin
      errors++;
      $display("FAIL bp_full got ready=%b d=%h exp ready=0 d=a0", s_ready[3], m00_data);
    end
    m00_ready = 1'b1;
    tick();
    checks++;
    if (m00_valid !== 1'b1 || m00_data !== 8'hA1) begin
      errors++;
      $display("FAIL bp_second got v=%b d=%h exp v=1 d=a1", m00_valid, m00_data);
    end
    s_valid[3] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL bp_drain%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_path_hold();
    sw = 3'd3; sw_vld = 1'b1;
    do_reset();
    tick();
    s_valid[3] = 1'b1; s_data[3] = 8'h5A;
    tick();
    s_valid[3] = 1'b0;
    sw = 3'd5; s_valid[5] = 1'b1; s_data[5] = 8'hC5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (curr_path !== 3'd3 || s_ready[5] !== 1'b0) begin
        errors++;
        $display("FAIL path_frozen got path=%0d r5=%b exp path=3 r5=0", curr_path, s_ready[5]);
      end
    end
    m00_ready = 1'b1;
    tick();
    checks++;
    if (curr_path !== 3'd5 || dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL path_switch got=%h exp=%h", dut_vec, exp_vec());
    end
    s_valid[5] = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_isolation();
    int bad = 0;
    sw = 3'd6; sw_vld = 1'b1;
    do_reset();
    m00_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      s_valid[1] = 1'b1; s_data[1] = 8'hE0 | 8'($urandom_range(0, 15));
      s_valid[6] = 1'($urandom_range(0, 1)); s_data[6] = 8'($urandom_range(0, 127));
      m00_ready = 1'($urandom_range(0, 3) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec() || s_ready[1] !== 1'b0) begin
        errors++;
        $display("FAIL isolation%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
      if (m00_valid && m00_data[7]) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL isolation_leak got=%0d exp=0", bad);
    end
    s_valid = '0;
    m00_ready = 1'b1;
    tick(); tick(); tick();
  endtask

  task automatic test_clk_en();
    logic [19:0] frozen;
    sw = 3'd2; sw_vld = 1'b1;
    do_reset();
    tick();
    m00_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      s_valid[2] = 1'b1; s_data[2] = 8'h30 + 8'(i);
      if (i == 4) frozen = exp_vec();
      clk_en = !(i >= 4 && i < 7);
      tick();
      checks++;
      if (dut_vec !== exp_vec() || (!clk_en && dut_vec !== frozen)) begin
        errors++;
        $display("FAIL clk_en%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    clk_en = 1'b1;
    s_valid[2] = 1'b0;
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    sw = 3'd7; sw_vld = 1'b1;
    do_reset();
    tick();
    s_valid[7] = 1'b1; s_data[7] = 8'h55;
    tick();
    s_data[7] = 8'h66;
    tick();
    checks++;
    if (dut_vec !== {3'd7, 8'h00, 1'b1, 8'h55}) begin
      errors++;
      $display("FAIL two_state got=%h exp=%h", dut_vec, {3'd7, 8'h00, 1'b1, 8'h55});
    end
    rst_n = 1'b0;
    tick();
    checks++;
    if (dut_vec !== 20'h0) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", dut_vec, 20'h0);
    end
    rst_n = 1'b1;
    m00_ready = 1'b1;
    tick();
    checks++;
    if (m00_valid !== 1'b0 || curr_path !== 3'd7 || s_ready !== 8'h80) begin
      errors++;
      $display("FAIL reset_idle_exit got=%h exp=%h", dut_vec, {3'd7, 8'h80, 1'b0, 8'h00});
    end
    s_valid = '0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (i % 40 == 0) sw = 3'($urandom_range(0, 7));
      sw_vld = ($urandom_range(0, 9) != 0);
      for (int k = 0; k < 8; k++) begin
        s_valid[k] = 1'($urandom_range(0, 1));
        s_data[k]  = 8'($urandom);
      end
      m00_ready = ($urandom_range(0, 9) < 7);
      clk_en    = ($urandom_range(0, 9) != 0);
      rst_n     = ($urandom_range(0, 199) != 0);
      tick();
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random%0d got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    rst_n = 1'b1;
    clk_en = 1'b1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++) s_data[k] = '0;
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_path_hold();
    test_isolation();
    test_clk_en();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
